// File: rtl/tictactoe_pkg.sv
// Shared encodings for the 4x4 board referee.
// Cell codes, winner codes, line count and FSM states.
package tictactoe_pkg;

   localparam logic [1:0] CODE_EMPTY = 2'b00;
   localparam logic [1:0] CODE_P1    = 2'b11;
   localparam logic [1:0] CODE_P2    = 2'b10;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;

   localparam int NUM_LINES = 10;
   localparam int NUM_CELLS = 16;

   typedef enum logic [1:0] {
      CELL_EMPTY,
      CELL_P1,
      CELL_P2
   } cell_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_e;

   // Codes other than the two player codes read as empty.
   function automatic cell_e classify(
      input logic [1:0] code,
      input logic [1:0] p1,
      input logic [1:0] p2
   );
      if (code == p1) return CELL_P1;
      if (code == p2) return CELL_P2;
      return CELL_EMPTY;
   endfunction

endpackage

// File: rtl/game_referee_line_lookup.sv
// Maps a winning-line index to its four cells and
// returns those cells' raw 2-bit codes from the board.
module line_lookup
   import tictactoe_pkg::*;
(
   input  logic [3:0]       line_idx,
   input  logic [31:0]      board,
   output logic [3:0][1:0]  cells
);

   logic [3:0][3:0] idx;
   logic [3:0]      col;

   assign col = line_idx - 4'd4;

   always_comb begin
      idx = '0;
      for (int k = 0; k < 4; k++) begin
         if (line_idx < 4'd4) begin
            idx[k] = {line_idx[1:0], 2'(k)};
         end else if (line_idx < 4'd8) begin
            idx[k] = {2'(k), col[1:0]};
         end else if (line_idx == 4'd8) begin
            idx[k] = 4'(5 * k);
         end else begin
            idx[k] = 4'(3 + 3 * k);
         end
      end
   end

   always_comb begin
      cells = '0;
      for (int k = 0; k < 4; k++) begin
         cells[k] = board[{idx[k], 1'b0} +: 2];
      end
   end

endmodule

// File: rtl/game_referee.sv
// Snapshots the packed board on change and scans the ten
// winning lines one per clock; reports winner/draw/game over.
module game_referee
   import tictactoe_pkg::*;
#(
   parameter logic [1:0] P1_CODE = CODE_P1,
   parameter logic [1:0] P2_CODE = CODE_P2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] num,
   output logic [1:0]  winner,
   output logic [3:0]  win_line,
   output logic        draw,
   output logic        game_over,
   output logic        result_valid,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [31:0] board_q, board_d;
   logic [3:0]  line_idx_q, line_idx_d;
   logic [1:0]  winner_q, winner_d;
   logic [3:0]  win_line_q, win_line_d;
   logic        draw_q, draw_d;
   logic        over_q, over_d;

   logic [3:0][1:0] cells;
   logic            line_p1;
   logic            line_p2;
   logic            board_full;
   logic            num_empty;

   line_lookup u_lookup (
      .line_idx (line_idx_q),
      .board    (board_q),
      .cells    (cells)
   );

   always_comb begin
      line_p1 = 1'b1;
      line_p2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (classify(cells[k], P1_CODE, P2_CODE) != CELL_P1)
            line_p1 = 1'b0;
         if (classify(cells[k], P1_CODE, P2_CODE) != CELL_P2)
            line_p2 = 1'b0;
      end
   end

   // Full-board test on the snapshot, all-empty test on the live input.
   always_comb begin
      board_full = 1'b1;
      num_empty  = 1'b1;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (classify(board_q[2*i +: 2], P1_CODE, P2_CODE) == CELL_EMPTY)
            board_full = 1'b0;
         if (classify(num[2*i +: 2], P1_CODE, P2_CODE) != CELL_EMPTY)
            num_empty = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      board_d    = board_q;
      line_idx_d = line_idx_q;
      winner_d   = winner_q;
      win_line_d = win_line_q;
      draw_d     = draw_q;
      over_d     = over_q;
      case (state_q)
         S_IDLE: begin
            if (num != board_q) begin
               board_d = num;
               if (over_q) begin
                  if (num_empty) begin
                     winner_d   = WINNER_NONE;
                     win_line_d = '0;
                     draw_d     = 1'b0;
                     over_d     = 1'b0;
                  end
               end else begin
                  line_idx_d = '0;
                  state_d    = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            if (line_p1) begin
               winner_d   = WINNER_P1;
               win_line_d = line_idx_q;
               state_d    = S_DONE;
            end else if (line_p2) begin
               winner_d   = WINNER_P2;
               win_line_d = line_idx_q;
               state_d    = S_DONE;
            end else if (line_idx_q == 4'(NUM_LINES - 1)) begin
               draw_d  = board_full;
               state_d = S_DONE;
            end else begin
               line_idx_d = line_idx_q + 4'd1;
            end
         end
         S_DONE: begin
            over_d  = (winner_q != WINNER_NONE) | draw_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         board_q    <= '0;
         line_idx_q <= '0;
         winner_q   <= WINNER_NONE;
         win_line_q <= '0;
         draw_q     <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         board_q    <= board_d;
         line_idx_q <= line_idx_d;
         winner_q   <= winner_d;
         win_line_q <= win_line_d;
         draw_q     <= draw_d;
         over_q     <= over_d;
      end
   end

   assign winner       = winner_q;
   assign win_line     = win_line_q;
   assign draw         = draw_q;
   assign game_over    = over_q;
   assign result_valid = (state_q == S_DONE);
   assign busy         = (state_q == S_SCAN);

endmodule

// File: tb/tb_game_referee.sv
// Randomized and directed bench for game_referee against a
// line-table reference model.
module tb_game_referee;

   logic        clk;
   logic        reset;
   logic [31:0] num;
   logic [1:0]  winner;
   logic [3:0]  win_line;
   logic        draw;
   logic        game_over;
   logic        result_valid;
   logic        busy;

   int errors = 0;
   int checks = 0;

   game_referee dut (
      .clk          (clk),
      .reset        (reset),
      .num          (num),
      .winner       (winner),
      .win_line     (win_line),
      .draw         (draw),
      .game_over    (game_over),
      .result_valid (result_valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int lines [10][4] = '{
      '{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15},
      '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
      '{0, 5, 10, 15}, '{3, 6, 9, 12}
   };

   // Model: first complete line in table order decides; else draw if full.
   function automatic void model(
      input  logic [31:0] b,
      output logic [1:0]  w,
      output int          ln,
      output logic        d,
      output int          nscan
   );
      logic [1:0] c;
      int n1, n2;
      w = 2'b00; ln = 0; d = 1'b0; nscan = 10;
      for (int l = 0; l < 10; l++) begin
         n1 = 0; n2 = 0;
         for (int k = 0; k < 4; k++) begin
            c = b[2*lines[l][k] +: 2];
            if (c == 2'b11) n1++;
            if (c == 2'b10) n2++;
         end
         if (n1 == 4 || n2 == 4) begin
            w = (n1 == 4) ? 2'b01 : 2'b10;
            ln = l;
            nscan = l + 1;
            return;
         end
      end
      d = 1'b1;
      for (int i = 0; i < 16; i++) begin
         c = b[2*i +: 2];
         if (c[1] == 1'b0) d = 1'b0;
      end
   endfunction

   function automatic logic [31:0] set_cells(
      input logic [31:0] b,
      input int a, input int bb, input int cc, input int dd,
      input logic [1:0] code
   );
      logic [31:0] r;
      r = b;
      r[2*a +: 2] = code;
      r[2*bb +: 2] = code;
      r[2*cc +: 2] = code;
      r[2*dd +: 2] = code;
      return r;
   endfunction

   task automatic do_reset();
      num = '0;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // Apply a board from a clean idle state and check the scan result.
   task automatic run_board(input string name, input logic [31:0] b);
      logic [1:0] ew;
      int el, ns, edges;
      logic ed;
      model(b, ew, el, ed, ns);
      num = b;
      edges = 0;
      while (edges < 20) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy: got %b want 1", name, busy);
            end
         end
         if (result_valid === 1'b1) break;
      end
      checks++;
      if (edges !== ns + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, edges, ns + 1);
      end
      checks++;
      if (winner !== ew || draw !== ed) begin
         errors++;
         $display("FAIL %s result: got w=%b d=%b want w=%b d=%b",
                  name, winner, draw, ew, ed);
      end
      if (ew != 2'b00) begin
         checks++;
         if (win_line !== 4'(el)) begin
            errors++;
            $display("FAIL %s win_line: got %0d want %0d", name, win_line, el);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (game_over !== (ew != 2'b00 || ed) || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s game_over: got %b rv=%b want %b rv=0",
                  name, game_over, result_valid, (ew != 2'b00 || ed));
      end
   endtask

   task automatic test_reset();
      num = 32'hFFFF_FFFF;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({winner, win_line, draw, game_over, result_valid, busy} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: got w=%b l=%0d d=%b go=%b rv=%b b=%b want 0",
                  winner, win_line, draw, game_over, result_valid, busy);
      end
      reset = 1'b1;
      run_board("reset_row0", 32'hFFFF_FFFF);
   endtask

   task automatic test_column();
      do_reset();
      run_board("column5", set_cells(32'h0, 1, 5, 9, 13, 2'b10));
   endtask

   task automatic test_antidiag();
      do_reset();
      run_board("antidiag", set_cells(32'h0, 3, 6, 9, 12, 2'b11));
   endtask

   task automatic test_draw();
      logic [31:0] b;
      b = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[2*(4*r+c) +: 2] = ((r % 2 == 0) == (c < 2)) ? 2'b11 : 2'b10;
      do_reset();
      run_board("draw", b);
   endtask

   task automatic test_random();
      logic [31:0] b;
      for (int t = 0; t < 40; t++) begin
         b = $urandom;
         if ($urandom_range(0, 1) == 1)
            b = set_cells(b, lines[t % 10][0], lines[t % 10][1],
                          lines[t % 10][2], lines[t % 10][3],
                          ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10);
         if (b == 32'h0) b = 32'h3;
         do_reset();
         run_board("random", b);
      end
   endtask

   task automatic test_midscan();
      logic [31:0] a, b;
      int edges;
      a = 32'h0000_0003;
      b = a | 32'h00FF_0000;
      do_reset();
      num = a;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      num = b;
      edges = 3;
      while (edges < 20 && result_valid !== 1'b1) begin
         @(posedge clk); #1;
         edges++;
      end
      checks++;
      if (edges !== 11 || winner !== 2'b00 || draw !== 1'b0) begin
         errors++;
         $display("FAIL midscan_first: got edges=%0d w=%b d=%b want 11 00 0",
                  edges, winner, draw);
      end
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while (edges < 20 && result_valid !== 1'b1);
      checks++;
      if (edges !== 5 || winner !== 2'b01 || win_line !== 4'd2) begin
         errors++;
         $display("FAIL midscan_second: got edges=%0d w=%b l=%0d want 5 01 2",
                  edges, winner, win_line);
      end
   endtask

   task automatic test_sticky_clear();
      logic [31:0] b;
      int bad;
      do_reset();
      run_board("sticky_win", 32'hFFFF_FFFF);
      b = 32'hFFFF_FFFF;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         b[2*i +: 2] = 2'b00;
         num = b;
         @(posedge clk); #1;
         if (i < 15) begin
            if (result_valid !== 1'b0 || winner !== 2'b01 || game_over !== 1'b1)
               bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL sticky_frozen: got %0d bad cycles want 0", bad);
      end
      checks++;
      if (winner !== 2'b00 || game_over !== 1'b0 || result_valid !== 1'b0 ||
          win_line !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL sticky_cleared: got w=%b go=%b rv=%b l=%0d b=%b want 0",
                  winner, game_over, result_valid, win_line, busy);
      end
   endtask

   task automatic test_reset_midscan();
      do_reset();
      num = set_cells(32'h0, 3, 6, 9, 12, 2'b11);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({winner, win_line, draw, game_over, result_valid, busy} !== 10'd0) begin
         errors++;
         $display("FAIL reset_midscan: got w=%b l=%0d go=%b rv=%b b=%b want 0",
                  winner, win_line, game_over, result_valid, busy);
      end
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      num = '0;
      test_reset();
      test_column();
      test_antidiag();
      test_draw();
      test_midscan();
      test_sticky_clear();
      test_reset_midscan();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
